beamformer_sequencer: RTL and testbench

Control-and-streaming stage wrapped around `brambeamformer`. On a `start` pulse it:
- sweeps the input signal RAM read address and holds `startbeamformer` high;
- steers `sumout_address` to the next write slot on each `usedataflag` beat, while the beamformer writes its results into the output RAM;
- reads the captured samples back and presents them on a valid/ready stream for the downstream transport (UART/DAC packer).

---
 rtl/beamformer_sequencer_if.sv | 39 +++
 rtl/beamformer_sequencer.sv | 126 ++++++++++++
 tb/tb_beamformer_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/beamformer_sequencer_if.sv
// beamformer_sequencer_if
//   Groups every non-clock/reset signal of the beamformer sequencer:
//   - frame control: start, busy, done, overflow
//   - input RAM read side: readin_address, readinen
//   - beamformer / output RAM side: startbeamformer, usedataflag,
//     sumout_address, sumouten, beam_value
//   - readout stream: out_data, out_valid, out_ready
//   The master modport is the sequencer; the slave modport is its environment.
interface beamformer_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] readin_address;
    logic              readinen;
    logic              startbeamformer;
    logic              usedataflag;
    logic [ADDR_W-1:0] sumout_address;
    logic              sumouten;
    logic [DATA_W-1:0] beam_value;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        input  start, usedataflag, beam_value, out_ready,
        output readin_address, readinen, startbeamformer, sumout_address,
               sumouten, out_data, out_valid, busy, done, overflow
    );

    modport slave (
        output start, usedataflag, beam_value, out_ready,
        input  readin_address, readinen, startbeamformer, sumout_address,
               sumouten, out_data, out_valid, busy, done, overflow
    );
endinterface

// File: rtl/beamformer_sequencer.sv
// beamformer_sequencer
//   Runs one beamformer frame per start pulse: sweeps the input RAM read
//   address (FILL), keeps the beamformer enabled until its results stop
//   arriving (DRAIN), steering the output RAM write address on each
//   usedataflag beat, then reads the captured results back out as a
//   valid/ready stream.
// Ports:
//   clk  - single rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - beamformer_sequencer_if master modport (control, RAM and stream)
module beamformer_sequencer #(
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 12,
    parameter int DRAIN_MAX = 64
) (
    input logic                    clk,
    input logic                    rst,
    beamformer_sequencer_if.master bus
);
    // Counters carry one extra bit so DEPTH itself is representable.
    localparam int CW = ADDR_W + 1;
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1   = CW'(DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, FILL, DRAIN, RD_REQ, RD_WAIT, RD_HOLD, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     fill_cnt, wr_cnt, rd_cnt, n_out;
    logic [DW-1:0]     drain_cnt;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              overflow_q;

    logic          wr_active, wr_inc, drain_exit;
    logic [CW-1:0] wr_next;

    // Write steering only listens to usedataflag while the beamformer runs.
    assign wr_active  = (state_q == FILL) || (state_q == DRAIN);
    assign wr_inc     = wr_active && bus.usedataflag && (wr_cnt != DEPTH_C);
    assign wr_next    = wr_cnt + CW'(wr_inc);
    assign drain_exit = (state_q == DRAIN) &&
                        ((wr_cnt == DEPTH_C) || (drain_cnt == DRAIN_LAST));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FILL;
            FILL:    if (fill_cnt == DEPTH_M1) state_d = DRAIN;
            // wr_next so a flag on the exit cycle is part of the readout
            DRAIN:   if (drain_exit) state_d = (wr_next == '0) ? DONE : RD_REQ;
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = RD_HOLD;
            RD_HOLD: if (bus.out_ready)
                         state_d = (rd_cnt == n_out - CW'(1)) ? DONE : RD_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_cnt    <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            n_out       <= '0;
            drain_cnt   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    fill_cnt   <= '0;
                    wr_cnt     <= '0;
                    rd_cnt     <= '0;
                    n_out      <= '0;
                    drain_cnt  <= '0;
                    overflow_q <= 1'b0;
                end
                FILL:  fill_cnt <= fill_cnt + CW'(1);
                DRAIN: begin
                    drain_cnt <= bus.usedataflag ? '0 : drain_cnt + DW'(1);
                    if (drain_exit) n_out <= wr_next;
                end
                RD_WAIT: begin
                    // RAM q is valid one cycle after the RD_REQ address
                    out_data_q  <= bus.beam_value;
                    out_valid_q <= 1'b1;
                end
                RD_HOLD: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    rd_cnt      <= rd_cnt + CW'(1);
                end
                default: ;
            endcase
            if (wr_active) begin
                wr_cnt <= wr_next;
                if (bus.usedataflag && (wr_cnt == DEPTH_C)) overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.readinen        = (state_q == FILL);
        bus.readin_address  = (state_q == FILL) ? fill_cnt[ADDR_W-1:0] : '0;
        bus.startbeamformer = wr_active;
        bus.sumouten        = (state_q == RD_REQ);
        bus.sumout_address  = '0;
        if (wr_active)
            bus.sumout_address = wr_cnt[ADDR_W-1:0];
        else if (state_q == RD_REQ || state_q == RD_WAIT || state_q == RD_HOLD)
            bus.sumout_address = rd_cnt[ADDR_W-1:0];
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.out_data  = out_data_q;
        bus.out_valid = out_valid_q;
        bus.overflow  = overflow_q;
    end
endmodule

// File: tb/tb_beamformer_sequencer.sv
// tb_beamformer_sequencer
//   Directed frames against a small beamformer/output-RAM model. Expected
//   stream samples go into a queue when a frame is launched; a negedge
//   monitor drives out_ready, pops and compares on every handshake and
//   checks that a stalled sample stays put.
module tb_beamformer_sequencer;
    localparam int DEPTH = 8, ADDR_W = 4, DATA_W = 12, DRAIN_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beamformer_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    beamformer_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output RAM model: written on beamformer result beats, 1-cycle read.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] wdata;
    always @(posedge clk) begin
        if (bus.usedataflag && bus.startbeamformer) ram[bus.sumout_address] <= wdata;
        if (bus.sumouten) bus.beam_value <= ram[bus.sumout_address];
    end

    int checks = 0, errors = 0;
    int done_cnt = 0, acc_cnt = 0, stall_cycles = 0;
    bit stall_en = 1'b0;
    bit prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: drives out_ready for the coming edge, then scores the handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            bus.out_ready = !(stall_en && acc_cnt == 2 && stall_cycles < 5);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got 0x%0h expected none", bus.out_data);
                end else begin
                    chk("sample", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
                acc_cnt++;
                prev_hold = 1'b0;
            end else if (bus.out_valid) begin
                stall_cycles++;
                prev_hold = 1'b1;
                prev_data = bus.out_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_readin_address"}, 32'(bus.readin_address), 0);
        chk({tag, "_readinen"}, 32'(bus.readinen), 0);
        chk({tag, "_startbeamformer"}, 32'(bus.startbeamformer), 0);
        chk({tag, "_sumout_address"}, 32'(bus.sumout_address), 0);
        chk({tag, "_sumouten"}, 32'(bus.sumouten), 0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 0);
    endtask

    // One frame: start, then nflags result beats beginning 3 cycles into FILL.
    task automatic run_frame(input int nflags, input int exp_ovf, input bit stall, input bit poke);
        int nexp;
        nexp = (nflags < DEPTH) ? nflags : DEPTH;
        done_cnt = 0;
        acc_cnt = 0;
        stall_cycles = 0;
        stall_en = stall;
        for (int i = 0; i < nexp; i++) exp_q.push_back(DATA_W'(12'h100 + i));
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        chk("fill_readinen", 32'(bus.readinen), 1);
        chk("fill_first_addr", 32'(bus.readin_address), 0);
        chk("start_clears_ovf", 32'(bus.overflow), 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < nflags; i++) begin
            bus.usedataflag = 1'b1;
            wdata = DATA_W'(12'h100 + i);
            @(negedge clk);
        end
        bus.usedataflag = 1'b0;
        if (poke) begin
            for (int k = 0; k < 200 && !bus.out_valid; k++) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
        end
        for (int k = 0; k < 400 && done_cnt == 0; k++) @(negedge clk);
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected one pulse");
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("samples_streamed", 32'(acc_cnt), 32'(nexp));
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
        chk("idle_busy", 32'(bus.busy), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.usedataflag = 1'b0;
        bus.out_ready = 1'b1;
        wdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_frame(8, 0, 1'b0, 1'b0);   // full frame
        run_frame(5, 0, 1'b0, 1'b0);   // drain timeout after 5 beats
        run_frame(10, 1, 1'b0, 1'b0);  // overflow, 8 streamed
        run_frame(0, 0, 1'b0, 1'b0);   // no beats: straight to done, clears ovf
        run_frame(8, 0, 1'b1, 1'b0);   // stall on sample 2

        // Reset in the middle of FILL.
        done_cnt = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midfill_rst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 0);
        chk("rst_idle", 32'(bus.busy), 0);

        run_frame(8, 0, 1'b0, 1'b1);   // start during readout is ignored

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
